// File: rtl/spi_flash_pkg.sv
// Purpose: shared constants, opcodes and FSM state type for the SPI flash read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcodes, default half-period, expected JEDEC ID (shared with RDID stage), FSM states.
package spi_flash_pkg;

  localparam logic [7:0]  OP_RDID      = 8'h9F;
  localparam logic [7:0]  OP_READ      = 8'h03;
  localparam int unsigned HALF_DEFAULT = 5;
  localparam logic [23:0] JEDEC_ID_EXP = 24'h202015;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD_ADDR,
    DATA,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_bit_engine.sv
// Purpose: SPI mode-0 bit engine: half-period timer, SCK generation, TX/RX shift registers.
// Latency: one bit per 2*HALF cycles; MISO sampled and MOSI advanced on the SCK falling cycle.
// Backpressure: none; the sequencing FSM gates it through cnt_en_i / sck_en_i.
// Ports: clk_i/rst_ni clock and async active-low reset; cnt_en_i runs the half timer;
//        sck_en_i lets SCK toggle; load_i/load_dat_i preload the 32-bit TX word; miso_i serial in;
//        sck_o, half_end_o (last cycle of a half), bit_done_o (SCK falling cycle), tx_msb_o,
//        rx_byte_o (RX byte including the bit being sampled this cycle).
module spi_bit_engine #(
  parameter int unsigned HALF = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cnt_en_i,
  input  logic        sck_en_i,
  input  logic        load_i,
  input  logic [31:0] load_dat_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        half_end_o,
  output logic        bit_done_o,
  output logic        tx_msb_o,
  output logic [7:0]  rx_byte_o
);

  localparam int unsigned      CNT_W    = $clog2(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;

  assign half_end_o = cnt_en_i && (cnt_q == CNT_LAST);
  // A bit completes at the end of the high half: SCK falls, MISO is captured
  // and the next MOSI bit is presented on the same edge.
  assign bit_done_o = sck_en_i && sck_q && half_end_o;
  assign rx_byte_o  = {rx_q[6:0], miso_i};
  assign sck_o      = sck_q;
  assign tx_msb_o   = tx_q[31];

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    if (!cnt_en_i || half_end_o) cnt_d = '0;
    else                         cnt_d = cnt_q + 1'b1;
    if (!sck_en_i)       sck_d = 1'b0;
    else if (half_end_o) sck_d = ~sck_q;
    if (load_i)          tx_d = load_dat_i;
    else if (bit_done_o) tx_d = {tx_q[30:0], 1'b0};
    if (bit_done_o)      rx_d = rx_byte_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
    end
  end

endmodule

// File: rtl/spi_flash_read.sv
// Purpose: issues SPI READ (0x03) + 24-bit address once the JEDEC ID is confirmed, streams bytes out.
// Latency: cs_n low 2*HALF + (32+8*len)*2*HALF cycles; rd_valid one cycle after each 8th sample.
// Backpressure: none on rd_data; start is only honoured while ready=1, otherwise dropped silently.
// Ports: sys_clk/sys_rst_n clock and async active-low reset; id_valid unlocks the block (sticky);
//        start/addr/len request; ready, busy status; rd_data/rd_valid byte stream; done end pulse;
//        spi_cs_n/spi_sck/spi_mosi/spi_miso flash pins (this block's copy, muxed at top level).
module spi_flash_read
  import spi_flash_pkg::*;
#(
  parameter int unsigned HALF    = HALF_DEFAULT,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           id_valid,
  input  logic                           start,
  input  logic [23:0]                    addr,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len,
  output logic                           ready,
  output logic                           busy,
  output logic [7:0]                     rd_data,
  output logic                           rd_valid,
  output logic                           done,
  input  logic                           spi_miso,
  output logic                           spi_mosi,
  output logic                           spi_cs_n,
  output logic                           spi_sck
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             id_ok_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;
  logic             done_q;

  logic       accept;
  logic       cnt_en;
  logic       sck_en;
  logic       half_end;
  logic       bit_done;
  logic       tx_msb;
  logic [7:0] rx_byte;
  logic       cmd_last;
  logic       byte_end;
  logic       last_byte;

  assign accept    = id_ok_q && (state_q == IDLE) && start && (len != '0);
  assign cnt_en    = (state_q != IDLE);
  assign sck_en    = (state_q == CMD_ADDR) || (state_q == DATA);
  assign cmd_last  = (state_q == CMD_ADDR) && bit_done && (bit_cnt_q == 6'd31);
  // In DATA only the low three bits of bit_cnt matter: they index the bit within the byte.
  assign byte_end  = (state_q == DATA) && bit_done && (bit_cnt_q[2:0] == 3'd7);
  assign last_byte = (byte_cnt_q == LEN_W'(1));

  spi_bit_engine #(
    .HALF(HALF)
  ) u_bit_engine (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .cnt_en_i   (cnt_en),
    .sck_en_i   (sck_en),
    .load_i     (accept),
    .load_dat_i ({OP_READ, addr}),
    .miso_i     (spi_miso),
    .sck_o      (spi_sck),
    .half_end_o (half_end),
    .bit_done_o (bit_done),
    .tx_msb_o   (tx_msb),
    .rx_byte_o  (rx_byte)
  );

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept)                 state_d = SETUP;
      SETUP:    if (half_end)               state_d = CMD_ADDR;
      CMD_ADDR: if (cmd_last)               state_d = DATA;
      DATA:     if (byte_end && last_byte)  state_d = HOLD;
      HOLD:     if (half_end)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy     = (state_q != IDLE);
    spi_cs_n = (state_q == IDLE);
    ready    = id_ok_q && (state_q == IDLE);
    spi_mosi = ((state_q == SETUP) || (state_q == CMD_ADDR)) ? tx_msb : 1'b0;
  end

  // Bit / byte counters
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (accept) begin
      bit_cnt_d  = '0;
      byte_cnt_d = len;
    end else if (bit_done) begin
      if (cmd_last) bit_cnt_d = '0;
      else          bit_cnt_d = bit_cnt_q + 6'd1;
      if (byte_end) byte_cnt_d = byte_cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      id_ok_q    <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      id_ok_q    <= id_ok_q | id_valid;
      if (byte_end) rd_data_q <= rx_byte;
      rd_valid_q <= byte_end;
      // done lands in the first IDLE cycle, where cs_n is already high.
      done_q     <= (state_q == HOLD) && half_end;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_flash_read.sv
// Purpose: randomized scoreboard bench for spi_flash_read with a behavioural SPI flash on miso.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_flash_read;
  import spi_flash_pkg::*;

  localparam int unsigned HALF = 5;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        id_valid  = 1'b0;
  logic        start     = 1'b0;
  logic [23:0] addr      = 24'h0;
  logic [8:0]  len       = 9'h0;
  logic        ready, busy, rd_valid, done;
  logic [7:0]  rd_data;
  logic        spi_miso, spi_mosi, spi_cs_n, spi_sck;

  spi_flash_read #(.HALF(HALF), .MAX_LEN(256)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .id_valid  (id_valid),
    .start     (start),
    .addr      (addr),
    .len       (len),
    .ready     (ready),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .spi_miso  (spi_miso),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] cmd_q[$];
  int          len_q[$];
  logic [7:0]  fmem[int unsigned];

  int done_cnt    = 0;
  int cs_fall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flash contents: explicit bytes where the test needs them, otherwise an address hash.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (fmem.exists({8'h00, a})) return fmem[{8'h00, a}];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
  endfunction

  // Behavioural flash: shifts in 32 command/address bits on SCK rise,
  // then shifts data out MSB-first after each SCK fall.
  initial begin
    int          rise_n;
    logic        fl_prev_sck;
    logic [31:0] cmd_sh;
    logic [23:0] fl_addr;
    logic [7:0]  b;
    int          k;
    spi_miso    = 1'b0;
    rise_n      = 0;
    fl_prev_sck = 1'b0;
    cmd_sh      = '0;
    fl_addr     = '0;
    forever begin
      @(spi_sck or spi_cs_n);
      if (spi_cs_n) begin
        rise_n      = 0;
        fl_prev_sck = spi_sck;
      end else if (spi_sck && !fl_prev_sck) begin
        fl_prev_sck = 1'b1;
        if (rise_n < 32) cmd_sh = {cmd_sh[30:0], spi_mosi};
        rise_n++;
        if (rise_n == 32) begin
          fl_addr = cmd_sh[23:0];
          if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
          else                   check("cmd_addr_bits", cmd_sh, cmd_q.pop_front());
        end
      end else if (!spi_sck && fl_prev_sck) begin
        fl_prev_sck = 1'b0;
        if (rise_n >= 32) begin
          k = rise_n - 32;
          b = flash_byte(fl_addr + 24'(k / 8));
          #1 spi_miso = b[7 - (k % 8)];
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int   cyc;
    int   last_vld_cyc;
    int   cs_low;
    int   n;
    logic prev_cs_n, prev_sck, prev_mosi;
    cyc = 0; last_vld_cyc = -1; cs_low = 0;
    prev_cs_n = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (spi_sck && !prev_sck) check("mosi_stable_at_rise", spi_mosi, prev_mosi);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
        else                   check("rd_data", rd_data, exp_q.pop_front());
        if (last_vld_cyc >= 0) check("rd_valid_gap", cyc - last_vld_cyc, 16 * HALF);
        last_vld_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_at_cs_rise", {prev_cs_n, spi_cs_n}, 2'b01);
      end
      if (!spi_cs_n && prev_cs_n) begin
        cs_fall_cnt++;
        cs_low       = 0;
        last_vld_cyc = -1;
      end
      if (!spi_cs_n) cs_low++;
      if (spi_cs_n && !prev_cs_n) begin
        if (len_q.size() == 0) check("cs_unexpected", 1, 0);
        else begin
          n = len_q.pop_front();
          if (sys_rst_n) begin
            check("cs_low_cycles", cs_low, 2 * HALF + (32 + 8 * n) * 2 * HALF);
            check("done_with_cs_rise", done, 1);
            check("busy_in_done", busy, 0);
            check("sck_idle_after", spi_sck, 0);
          end else begin
            check("no_done_on_abort", done, 0);
          end
        end
      end
      prev_cs_n = spi_cs_n;
      prev_sck  = spi_sck;
      prev_mosi = spi_mosi;
    end
  end

  task automatic wait_ready(input int budget);
    int i;
    for (i = 0; i < budget && !ready; i++) @(negedge sys_clk);
    check("ready_wait", ready, 1);
  endtask

  task automatic issue(input logic [23:0] a, input int n);
    wait_ready(3000);
    cmd_q.push_back({OP_READ, a});
    len_q.push_back(n);
    for (int i = 0; i < n; i++) exp_q.push_back(flash_byte(a + 24'(i)));
    @(negedge sys_clk);
    start = 1'b1; addr = a; len = 9'(n);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge sys_clk);
    check("done_wait", done_cnt >= target, 1);
  endtask

  task automatic run_txn(input logic [23:0] a, input int n);
    int target;
    target = done_cnt + 1;
    issue(a, n);
    wait_done(target, 1000 + 100 * n);
    @(negedge sys_clk);
    check("bytes_all_seen", exp_q.size(), 0);
    check("one_done", done_cnt, target);
  endtask

  initial begin
    int falls0, dc0, target;
    logic [23:0] ra;

    // 1. reset values
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("ready_locked", ready, 0);

    // 2. start before the ID is confirmed is dropped
    falls0 = cs_fall_cnt;
    start = 1'b1; addr = 24'h000100; len = 9'd1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (1000) @(negedge sys_clk);
    check("no_cs_while_locked", cs_fall_cnt, falls0);
    check("still_locked", ready, 0);
    id_valid = 1'b1;
    @(negedge sys_clk);
    id_valid = 1'b0;
    check("ready_after_id", ready, 1);

    // 3. single byte
    fmem[32'h000100] = 8'hA5;
    run_txn(24'h000100, 1);

    // 4. four bytes across the address wrap
    fmem[32'hFFFFFE] = 8'h11;
    fmem[32'hFFFFFF] = 8'h22;
    fmem[32'h000000] = 8'h33;
    fmem[32'h000001] = 8'h44;
    run_txn(24'hFFFFFE, 4);

    // 5. start while busy, then len==0 while idle: both dropped
    ra = 24'($urandom);
    target = done_cnt + 1;
    issue(ra, 2);
    repeat (100) @(negedge sys_clk);
    check("busy_mid", busy, 1);
    check("not_ready_mid", ready, 0);
    start = 1'b1; addr = ~ra; len = 9'd3;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(target, 2000);
    falls0 = cs_fall_cnt;
    dc0    = done_cnt;
    repeat (200) @(negedge sys_clk);
    check("no_extra_cs", cs_fall_cnt, falls0);
    check("no_extra_done", done_cnt, dc0);
    check("bytes_busy_case", exp_q.size(), 0);
    check("ready_idle", ready, 1);
    start = 1'b1; addr = 24'h0ABCDE; len = 9'd0;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (200) @(negedge sys_clk);
    check("len0_no_cs", cs_fall_cnt, falls0);
    check("len0_no_done", done_cnt, dc0);

    // 6. reset in the middle of DATA
    issue(24'($urandom), 4);
    for (int i = 0; i < 3000 && exp_q.size() > 2; i++) @(negedge sys_clk);
    check("two_bytes_before_abort", exp_q.size() <= 2, 1);
    repeat (20) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sck", spi_sck, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 0);
    exp_q.delete();
    dc0 = done_cnt;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (400) @(negedge sys_clk);
    check("abort_no_done", done_cnt, dc0);
    check("relock_after_reset", ready, 0);
    id_valid = 1'b1;
    @(negedge sys_clk);
    id_valid = 1'b0;
    check("ready_after_reid", ready, 1);

    // 7. random transactions
    for (int t = 0; t < 6; t++) run_txn(24'($urandom), $urandom_range(1, 6));

    check("cmd_q_drained", cmd_q.size(), 0);
    check("len_q_drained", len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
